// File: rtl/pipe_stage_reg.sv
// Pipeline register stage with a valid/ready handshake and a one-entry skid
// buffer. o_Ready is registered, so there is no combinational path from
// i_Ready to o_Ready, and the stage still sustains one transfer per cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_EMPTY | no entry held; o_Valid = 0, o_Ready = 1
// ST_ONE   | main register holds the head entry; o_Ready = 1
// ST_TWO   | main holds the head, skid holds the next entry; o_Ready = 0
module pipe_stage_reg #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Flush,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_wData,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_rData,
    output logic [1:0]       o_Count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             ready_q;
    logic             ready_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;

    logic             in_acc;
    logic             out_acc;

    // Handshake qualifiers; both depend only on registered state plus inputs.
    assign o_Valid = (state_q != ST_EMPTY);
    assign o_Ready = ready_q;
    assign o_rData = main_q;
    assign in_acc  = i_Valid & ready_q;
    assign out_acc = o_Valid & i_Ready;

    // State, ready flag and payload registers; reset restores the empty stage.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and payload-load decisions; flush overrides every transition
    // and never touches the payload, so o_rData keeps its last value.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (i_Flush) begin
            state_d = ST_EMPTY;
            ready_d = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_acc) begin
                        main_d  = i_wData;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_acc && out_acc) begin
                        main_d = i_wData;
                    end else if (in_acc) begin
                        skid_d  = i_wData;
                        state_d = ST_TWO;
                        ready_d = 1'b0;
                    end else if (out_acc) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Input cannot be accepted here because ready_q is low.
                    if (out_acc) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                        ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // Occupancy decode for o_Count.
    always_comb begin
        o_Count = 2'd0;
        case (state_q)
            ST_ONE:  o_Count = 2'd1;
            ST_TWO:  o_Count = 2'd2;
            default: o_Count = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboard queue of accepted words,
// a directed vector table, and randomized traffic with flush.
module tb_pipe_stage_reg;

    localparam int unsigned      W   = 32;
    localparam logic [W-1:0]     RV  = 32'hDEAD_BEEF;

    logic         i_Clk = 1'b0;
    logic         i_Reset;
    logic         i_Flush;
    logic         i_Valid;
    logic         o_Ready;
    logic [W-1:0] i_wData;
    logic         o_Valid;
    logic         i_Ready;
    logic [W-1:0] o_rData;
    logic [1:0]   o_Count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] sb[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         f;
        logic [1:0]   cnt;
        logic         rdy;
        logic         vld;
        logic [W-1:0] dat;
    } vec_t;

    vec_t vt[14];

    pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Flush (i_Flush),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_wData (i_wData),
        .o_Valid (o_Valid),
        .i_Ready (i_Ready),
        .o_rData (o_rData),
        .o_Count (o_Count)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called right after a falling edge. Drives one cycle of inputs, updates the
    // scoreboard for the coming rising edge, then checks state at the next
    // falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic         exp_in;
        logic         exp_out;
        logic         stall;
        logic [W-1:0] pre_d;
        i_Valid = v;
        i_wData = d;
        i_Ready = r;
        i_Flush = f;
        exp_in  = v && (sb.size() < 2);
        exp_out = r && (sb.size() > 0);
        stall   = (sb.size() > 0) && !r && !f;
        pre_d   = o_rData;
        if (exp_out) begin
            chk("deliver", {32'd0, o_rData}, {32'd0, sb[0]});
            void'(sb.pop_front());
        end
        if (f) sb.delete();
        else if (exp_in) sb.push_back(d);
        @(posedge i_Clk);
        @(negedge i_Clk);
        chk("count", {62'd0, o_Count}, 64'(sb.size()));
        chk("valid", {63'd0, o_Valid}, {63'd0, sb.size() > 0});
        chk("ready", {63'd0, o_Ready}, {63'd0, sb.size() < 2});
        if (sb.size() > 0) chk("head", {32'd0, o_rData}, {32'd0, sb[0]});
        if (stall) chk("stable_data", {32'd0, o_rData}, {32'd0, pre_d});
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'hA, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hA};
        vt[1]  = '{1'b1, 32'hB, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hA};
        vt[2]  = '{1'b1, 32'hC, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hA};
        vt[3]  = '{1'b1, 32'hC, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'hB};
        vt[4]  = '{1'b1, 32'hC, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'hC};
        vt[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'hC};
        vt[6]  = '{1'b1, 32'hD, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hD};
        vt[7]  = '{1'b1, 32'hE, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hD};
        vt[8]  = '{1'b1, 32'h99, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'hD};
        vt[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'hD};
        vt[10] = '{1'b1, 32'hF, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hF};
        vt[11] = '{1'b1, 32'h77, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'hF};
        vt[12] = '{1'b1, 32'h1234, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h1234};
        vt[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h1234};

        i_Reset = 1'b1;
        i_Flush = 1'b0;
        i_Valid = 1'b0;
        i_Ready = 1'b0;
        i_wData = '0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        chk("rst_count", {62'd0, o_Count}, 64'd0);
        chk("rst_valid", {63'd0, o_Valid}, 64'd0);
        chk("rst_ready", {63'd0, o_Ready}, 64'd1);
        chk("rst_data", {32'd0, o_rData}, {32'd0, RV});
        i_Reset = 1'b0;

        // Fill the stage, then hit it with an asynchronous reset mid-cycle.
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 32'h66, 1'b0, 1'b0);
        #2 i_Reset = 1'b1;
        #1;
        chk("arst_count", {62'd0, o_Count}, 64'd0);
        chk("arst_valid", {63'd0, o_Valid}, 64'd0);
        chk("arst_ready", {63'd0, o_Ready}, 64'd1);
        chk("arst_data", {32'd0, o_rData}, {32'd0, RV});
        sb.delete();
        @(negedge i_Clk);
        i_Reset = 1'b0;
        cycle(1'b1, 32'h1, 1'b0, 1'b0);
        chk("first_after_rst", {32'd0, o_rData}, 64'h1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming at full rate.
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, W'(k), 1'b1, 1'b0);
            chk("stream_data", {32'd0, o_rData}, 64'(k));
            chk("stream_ready", {63'd0, o_Ready}, 64'd1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Directed backpressure and flush vectors.
        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].v, vt[i].d, vt[i].r, vt[i].f);
            chk("tbl_count", {62'd0, o_Count}, {62'd0, vt[i].cnt});
            chk("tbl_ready", {63'd0, o_Ready}, {63'd0, vt[i].rdy});
            chk("tbl_valid", {63'd0, o_Valid}, {63'd0, vt[i].vld});
            chk("tbl_data", {32'd0, o_rData}, {32'd0, vt[i].dat});
        end

        // Random traffic against the scoreboard.
        for (int n = 0; n < 10000; n++) begin
            cycle(1'($urandom_range(1, 0)), $urandom(), 1'($urandom_range(1, 0)),
                  ($urandom_range(99, 0) < 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
